uart_rx_ctrl: RTL and testbench

Complete receive-side sequencer for the UART Rx path. It synchronizes the serial line and generates the oversampling baud tick. It detects and qualifies the start bit, samples data bits at mid-bit and checks the stop bit. Received bytes go to a single-entry valid/ready output register, with done, framing-error and overrun status toward the host-side FIFO/register block.

---
 rtl/uart_rx_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: line synchronizer, oversampling prescaler, start/data/stop
// framing FSM and a single-entry valid/ready output register with status pulses.
module uart_rx_ctrl #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned OVS       = 16,
  parameter int unsigned DIV_W     = 16
) (
  input  logic                 clk,
  input  logic                 rx_arst_n,
  input  logic                 rx_rst,
  input  logic                 rx_en,
  input  logic                 rx,
  input  logic [DIV_W-1:0]     baud_div,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 busy_flag,
  output logic                 done_flag,
  output logic                 err_flag,
  output logic                 overrun_flag
);

  localparam int unsigned SMP_W = $clog2(OVS);
  localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [SMP_W-1:0] SMP_MID  = SMP_W'(OVS / 2 - 1);
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(OVS - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state_q, state_d;
  logic                   rx_m, rx_s, rx_s_d;
  logic [DIV_W-1:0]       presc_q, presc_d;
  logic [SMP_W-1:0]       sample_q, sample_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_d;
  logic                   valid_d, done_d, err_d, ovr_d;
  logic                   tick;
  logic                   fall;

  assign tick = (presc_q == baud_div);
  assign fall = rx_s_d & ~rx_s;

  // Two-flop synchronizer plus one delay stage for edge detection
  always_ff @(posedge clk or negedge rx_arst_n) begin
    if (!rx_arst_n) begin
      rx_m   <= 1'b1;
      rx_s   <= 1'b1;
      rx_s_d <= 1'b1;
    end else if (rx_rst) begin
      rx_m   <= 1'b1;
      rx_s   <= 1'b1;
      rx_s_d <= 1'b1;
    end else begin
      rx_m   <= rx;
      rx_s   <= rx_m;
      rx_s_d <= rx_s;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    presc_d  = tick ? '0 : presc_q + DIV_W'(1);
    sample_d = sample_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    data_d   = rx_data;
    valid_d  = rx_valid & ~rx_ready;
    done_d   = 1'b0;
    err_d    = 1'b0;
    ovr_d    = overrun_flag;

    case (state_q)
      IDLE: begin
        if (fall && rx_en) begin
          state_d  = START;
          presc_d  = '0;
          sample_d = '0;
        end
      end
      START: begin
        if (tick) begin
          if (sample_q == SMP_MID) begin
            sample_d = '0;
            bit_d    = '0;
            state_d  = rx_s ? IDLE : DATA;
          end else begin
            sample_d = sample_q + SMP_W'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (sample_q == SMP_LAST) begin
            sample_d = '0;
            shift_d  = {rx_s, shift_q[DATA_BITS-1:1]};
            bit_d    = bit_q + BIT_W'(1);
            if (bit_q == BIT_LAST) state_d = STOP;
          end else begin
            sample_d = sample_q + SMP_W'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (sample_q == SMP_LAST) begin
            state_d  = IDLE;
            sample_d = '0;
            if (!rx_s) begin
              err_d = 1'b1;
            end else if (!rx_valid || rx_ready) begin
              // a load in the same cycle as a read keeps rx_valid set
              data_d  = shift_q;
              valid_d = 1'b1;
              done_d  = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            sample_d = sample_q + SMP_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Disabling the receiver mid-frame silently abandons the frame
    if (state_q != IDLE && !rx_en) begin
      state_d  = IDLE;
      sample_d = '0;
      data_d   = rx_data;
      valid_d  = rx_valid & ~rx_ready;
      done_d   = 1'b0;
      err_d    = 1'b0;
      ovr_d    = overrun_flag;
    end

    if (rx_rst) begin
      state_d  = IDLE;
      presc_d  = '0;
      sample_d = '0;
      bit_d    = '0;
      shift_d  = '0;
      data_d   = '0;
      valid_d  = 1'b0;
      done_d   = 1'b0;
      err_d    = 1'b0;
      ovr_d    = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rx_arst_n) begin
    if (!rx_arst_n) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      sample_q     <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      busy_flag    <= 1'b0;
      done_flag    <= 1'b0;
      err_flag     <= 1'b0;
      overrun_flag <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      sample_q     <= sample_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      rx_data      <= data_d;
      rx_valid     <= valid_d;
      busy_flag    <= (state_d != IDLE);
      done_flag    <= done_d;
      err_flag     <= err_d;
      overrun_flag <= ovr_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: table of single frames plus corner-case sequences.
module tb_uart_rx_ctrl;

  logic        clk;
  logic        rx_arst_n;
  logic        rx_rst;
  logic        rx_en;
  logic        rx;
  logic [15:0] baud_div;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        busy_flag;
  logic        done_flag;
  logic        err_flag;
  logic        overrun_flag;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int busy_cnt = 0;
  int inv_bad  = 0;

  uart_rx_ctrl #(.DATA_BITS(8), .OVS(16), .DIV_W(16)) dut (
    .clk          (clk),
    .rx_arst_n    (rx_arst_n),
    .rx_rst       (rx_rst),
    .rx_en        (rx_en),
    .rx           (rx),
    .baud_div     (baud_div),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .busy_flag    (busy_flag),
    .done_flag    (done_flag),
    .err_flag     (err_flag),
    .overrun_flag (overrun_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Running event totals; tests compare deltas
  always @(negedge clk) begin
    if (done_flag) done_cnt++;
    if (err_flag) err_cnt++;
    if (busy_flag) busy_cnt++;
    if ((done_flag && err_flag) || (busy_flag && (done_flag || err_flag))) inv_bad++;
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_valid;
    int         exp_done;
    int         exp_err;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rx_rst = 1'b1;
    @(negedge clk);
    rx_rst = 1'b0;
  endtask

  // Bit period = 64 clocks at baud_div=3. Start bit driven at negedge 0,
  // stop bit occupies negedges 576..639, then idle high until 703.
  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input int ready_at, input int en_drop_at,
                            output int done_at);
    logic [7:0] dd;
    dd = d;
    done_at = -1;
    @(negedge clk);
    rx = 1'b0;
    for (int c = 1; c < 704; c++) begin
      @(negedge clk);
      if (done_flag && done_at < 0) done_at = c;
      if (c < 64)       rx = 1'b0;
      else if (c < 576) rx = dd[(c / 64) - 1];
      else if (c < 640) rx = stop;
      else              rx = 1'b1;
      rx_ready = (c == ready_at);
      rx_en = !(en_drop_at > 0 && c >= en_drop_at && c < 640);
    end
    rx_ready = 1'b0;
    rx_en = 1'b1;
  endtask

  int d0, e0, b0, done_at;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1'b1, 1, 0};
    vecs[1] = '{8'h3C, 1'b0, 8'h00, 1'b0, 0, 1};
    vecs[2] = '{8'h00, 1'b1, 8'h00, 1'b1, 1, 0};
    vecs[3] = '{8'hFF, 1'b1, 8'hFF, 1'b1, 1, 0};
    vecs[4] = '{8'h6E, 1'b1, 8'h6E, 1'b1, 1, 0};

    rx_arst_n = 1'b0;
    rx_rst    = 1'b0;
    rx_en     = 1'b1;
    rx        = 1'b1;
    rx_ready  = 1'b0;
    baud_div  = 16'd3;
    repeat (3) @(negedge clk);
    rx_arst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset rx_data", int'(rx_data), 0);
    chk("reset rx_valid", int'(rx_valid), 0);
    chk("reset busy", int'(busy_flag), 0);
    chk("reset done", int'(done_flag), 0);
    chk("reset err", int'(err_flag), 0);
    chk("reset overrun", int'(overrun_flag), 0);

    // Single frames from a cleared receiver, consumer never ready
    for (int i = 0; i < 5; i++) begin
      pulse_rst();
      d0 = done_cnt; e0 = err_cnt; b0 = busy_cnt;
      send_frame(vecs[i].data, vecs[i].stop, -1, 0, done_at);
      chk($sformatf("vec%0d rx_data", i), int'(rx_data), int'(vecs[i].exp_data));
      chk($sformatf("vec%0d rx_valid", i), int'(rx_valid), int'(vecs[i].exp_valid));
      chk($sformatf("vec%0d done pulses", i), done_cnt - d0, vecs[i].exp_done);
      chk($sformatf("vec%0d err pulses", i), err_cnt - e0, vecs[i].exp_err);
      chk($sformatf("vec%0d busy cycles", i), busy_cnt - b0, 608);
      chk($sformatf("vec%0d busy after", i), int'(busy_flag), 0);
    end

    // Short low glitch: rejected at the mid start-bit sample
    d0 = done_cnt; e0 = err_cnt; b0 = busy_cnt;
    @(negedge clk);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (100) @(negedge clk);
    chk("glitch busy cycles", busy_cnt - b0, 32);
    chk("glitch done", done_cnt - d0, 0);
    chk("glitch err", err_cnt - e0, 0);
    chk("glitch rx_valid", int'(rx_valid), 1);
    chk("glitch rx_data", int'(rx_data), 'h6E);

    // Framing error followed by a good frame
    pulse_rst();
    e0 = err_cnt; d0 = done_cnt;
    send_frame(8'h3C, 1'b0, -1, 0, done_at);
    chk("ferr err pulses", err_cnt - e0, 1);
    chk("ferr rx_valid", int'(rx_valid), 0);
    chk("ferr rx_data", int'(rx_data), 0);
    send_frame(8'h81, 1'b1, -1, 0, done_at);
    chk("after ferr rx_data", int'(rx_data), 'h81);
    chk("after ferr rx_valid", int'(rx_valid), 1);
    chk("after ferr done pulses", done_cnt - d0, 1);

    // Overrun: second byte lost while the first is unread
    pulse_rst();
    d0 = done_cnt;
    send_frame(8'h11, 1'b1, -1, 0, done_at);
    send_frame(8'h22, 1'b1, -1, 0, done_at);
    chk("ovr rx_data", int'(rx_data), 'h11);
    chk("ovr flag", int'(overrun_flag), 1);
    chk("ovr done pulses", done_cnt - d0, 1);
    chk("ovr rx_valid", int'(rx_valid), 1);
    pulse_rst();
    @(negedge clk);
    chk("ovr cleared", int'(overrun_flag), 0);
    chk("ovr valid cleared", int'(rx_valid), 0);

    // Read coincident with the stop-sample load: load wins, no overrun
    send_frame(8'h11, 1'b1, -1, 0, done_at);
    send_frame(8'h55, 1'b1, 610, 0, done_at);
    chk("simul rx_data", int'(rx_data), 'h55);
    chk("simul rx_valid", int'(rx_valid), 1);
    chk("simul overrun", int'(overrun_flag), 0);
    chk("simul done cycle", done_at, 611);

    // Receiver disabled in the middle of data bit 4
    pulse_rst();
    d0 = done_cnt; e0 = err_cnt; b0 = busy_cnt;
    send_frame(8'hA5, 1'b1, -1, 352, done_at);
    chk("abort busy cycles", busy_cnt - b0, 350);
    chk("abort done", done_cnt - d0, 0);
    chk("abort err", err_cnt - e0, 0);
    chk("abort rx_valid", int'(rx_valid), 0);
    send_frame(8'hF0, 1'b1, -1, 0, done_at);
    chk("post abort rx_data", int'(rx_data), 'hF0);
    chk("post abort rx_valid", int'(rx_valid), 1);
    chk("post abort done cycle", done_at, 611);

    chk("flag exclusivity", inv_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
